// File: rtl/cpu_memory_responder_pkg.sv
// Shared types and constants for the CPU memory responder.
// State encoding and bus widths shared with the CPU.
package cpu_memory_responder_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int WR_COUNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_mem_array.sv
// Storage array: async clear, one sync write port,
// one combinational read port.
module cpu_mem_array
  import cpu_memory_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear every word on reset, otherwise commit the muxed write.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_memory_responder.sv
// Memory-side responder for the CPU bus with boot loader.
// Holds the CPU in clear until the image is loaded.
module cpu_memory_responder
  import cpu_memory_responder_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DEPTH          = 16,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_clr,
  output logic              boot_done,
  output logic              err,
  output logic [7:0]        wr_count
);

  localparam logic [3:0] W_REL = 4'(RELEASE_CYCLES);
  localparam logic [7:0] W_MAX = 8'(WR_COUNT_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_err;
  logic [7:0]        r_wr_count;
  logic              w_ld_ready;
  logic              w_cpu_clr;
  logic              w_boot_done;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, handshake outputs and write-port mux.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_ready  = 1'b0;
    w_cpu_clr   = 1'b1;
    w_boot_done = 1'b0;
    w_we        = 1'b0;
    w_waddr     = ld_addr;
    w_wdata     = ld_data;
    unique case (r_state)
      IDLE, LOADING: begin
        w_ld_ready = 1'b1;
        if (ld_valid) begin
          w_we        = 1'b1;
          w_state_nxt = ld_last ? RELEASE : LOADING;
        end
      end
      RELEASE: begin
        if (r_cnt == W_REL) w_state_nxt = RUN;
      end
      RUN: begin
        w_cpu_clr   = 1'b0;
        w_boot_done = 1'b1;
        w_we        = write;
        w_waddr     = address;
        w_wdata     = memoryIn;
      end
      default: ;
    endcase
  end

  // Release delay: count up to RELEASE_CYCLES, then hold.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (r_state == RELEASE && r_cnt != W_REL) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Sticky collision flag and saturating write counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else if (r_state == RUN && write) begin
      if (read) r_err <= 1'b1;
      if (r_wr_count != W_MAX) r_wr_count <= r_wr_count + 8'd1;
    end
  end

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .clr     (clr),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (address),
    .o_rdata (w_rdata)
  );

  assign memoryOut = (r_state == RUN) ? w_rdata : '0;
  assign ld_ready  = w_ld_ready;
  assign cpu_clr   = w_cpu_clr;
  assign boot_done = w_boot_done;
  assign err       = r_err;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Testbench for cpu_memory_responder.
// Directed boot sequence plus random CPU traffic vs a model.
module tb_cpu_memory_responder;

  localparam int REL = 2;

  logic       clk;
  logic       clr;
  logic       read;
  logic       write;
  logic [3:0] address;
  logic [7:0] memoryIn;
  logic [7:0] memoryOut;
  logic       ld_valid;
  logic       ld_ready;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       cpu_clr;
  logic       boot_done;
  logic       err;
  logic [7:0] wr_count;

  logic [7:0] mem_m [16];
  int         wcnt_m;
  bit         err_m;
  int         n_tests;
  int         n_fail;

  cpu_memory_responder #(
    .ADDR_W         (4),
    .DATA_W         (8),
    .DEPTH          (16),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .read      (read),
    .write     (write),
    .address   (address),
    .memoryIn  (memoryIn),
    .memoryOut (memoryOut),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .cpu_clr   (cpu_clr),
    .boot_done (boot_done),
    .err       (err),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    wcnt_m = 0;
    err_m  = 1'b0;
  endtask

  task automatic ld_byte(input logic [3:0] a,
                         input logic [7:0] d,
                         input logic       last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    #1 chk("ld_ready_load", ld_ready, 1);
    tick();
    mem_m[a] = d;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_cpu_clr", cpu_clr, 1);
      chk("gap_ld_ready", ld_ready, 1);
      chk("gap_boot_done", boot_done, 0);
    end
  endtask

  task automatic release_wait(input logic junk);
    chk("rel_ld_ready", ld_ready, 0);
    chk("rel_cpu_clr0", cpu_clr, 1);
    if (junk) begin
      ld_valid = 1'b1;
      ld_addr  = 4'd9;
      ld_data  = 8'h99;
    end
    for (int i = 0; i < REL; i++) begin
      tick();
      chk("rel_cpu_clr", cpu_clr, 1);
      chk("rel_memout0", memoryOut, 0);
    end
    tick();
    ld_valid = 1'b0;
    chk("run_cpu_clr", cpu_clr, 0);
    chk("run_boot_done", boot_done, 1);
    chk("run_ld_ready", ld_ready, 0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1 chk(tag, memoryOut, mem_m[a]);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a,
                        input logic [7:0] d,
                        input logic       r);
    address  = a;
    memoryIn = d;
    write    = 1'b1;
    read     = r;
    #1 chk("rdw_old", memoryOut, mem_m[a]);
    tick();
    mem_m[a] = d;
    if (wcnt_m < 255) wcnt_m++;
    if (r) err_m = 1'b1;
    write = 1'b0;
    read  = 1'b0;
    #1;
    chk("wr_new", memoryOut, mem_m[a]);
    chk("wr_count", wr_count, 8'(wcnt_m));
    chk("err", err, err_m);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    logic       w;
    logic       r;
    n_tests  = 0;
    n_fail   = 0;
    clr      = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    address  = '0;
    memoryIn = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_last  = 1'b0;
    model_clear();

    tick();
    tick();
    chk("rst_cpu_clr", cpu_clr, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_memout", memoryOut, 0);
    clr = 1'b1;
    gap(1);

    ld_byte(4'd0, 8'h47, 1'b0);
    gap(2);
    ld_byte(4'd1, 8'h06, 1'b0);
    ld_byte(4'd2, 8'h54, 1'b0);
    ld_byte(4'd3, 8'h11, 1'b0);
    gap(3);
    address  = 4'd0;
    memoryIn = 8'hFF;
    write    = 1'b1;
    tick();
    write    = 1'b0;
    chk("ld_wr_ign_clr", cpu_clr, 1);
    ld_byte(4'd3, 8'h22, 1'b0);
    gap(1);
    ld_byte(4'd6, 8'h02, 1'b0);
    gap(2);
    ld_byte(4'd7, 8'h03, 1'b1);
    release_wait(1'b1);

    chk("wr_count_boot", wr_count, 0);
    read_all("boot_image");

    cpu_wr(4'd4, 8'h05, 1'b0);

    ld_valid = 1'b1;
    ld_addr  = 4'd9;
    ld_data  = 8'h99;
    tick();
    tick();
    ld_valid = 1'b0;
    address  = 4'd9;
    #1 chk("run_ld_ign", memoryOut, 0);
    chk("run_ld_wrcnt", wr_count, 8'(wcnt_m));

    cpu_wr(4'd5, 8'hAA, 1'b1);
    tick();
    chk("err_sticky", err, 1);

    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (w) begin
        cpu_wr(a, d, r);
      end else begin
        address = a;
        read    = r;
        #1 chk("rnd_rd", memoryOut, mem_m[a]);
        tick();
        read = 1'b0;
        chk("rnd_rd_cnt", wr_count, 8'(wcnt_m));
      end
    end

    for (int i = 0; i < 260; i++) begin
      address  = 4'($urandom_range(0, 15));
      memoryIn = 8'($urandom);
      write    = 1'b1;
      tick();
      mem_m[address] = memoryIn;
      if (wcnt_m < 255) wcnt_m++;
    end
    write = 1'b0;
    chk("wr_count_sat", wr_count, 255);
    read_all("post_sat");

    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("mid_cpu_clr", cpu_clr, 1);
    chk("mid_boot_done", boot_done, 0);
    chk("mid_wr_count", wr_count, 0);
    chk("mid_err", err, 0);
    chk("mid_ld_ready", ld_ready, 1);
    chk("mid_memout", memoryOut, 0);
    #2 clr = 1'b1;
    model_clear();
    tick();

    ld_byte(4'd0, 8'h5A, 1'b1);
    release_wait(1'b0);
    read_all("reboot");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
